// File: rtl/i2c_master_burst.sv
// Burst I2C register master: START, address/register phase, burst write or
// repeated-START burst read, STOP. Optional SCL stretching via I2C_CLOCK_STRETCH_EN.
module i2c_master_burst #(
  parameter logic [6:0] SLAVE_ADDR = 7'h18,
  parameter int         CLK_DIV    = 4,
  parameter int         CNT_W      = 4
) (
  input  logic             i2c_clk,
  input  logic             RST,
  input  logic             start,
  input  logic             r_w,
  input  logic [7:0]       reg_addr,
  input  logic [CNT_W-1:0] num_bytes,
  input  logic [7:0]       wr_data,
  output logic             wr_data_req,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  inout  wire              I2C_SCLK,
  inout  wire              I2C_SDAT
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_A, REG, ACK_R, RSTART, ADDR_R,
    ACK_AR, WR_BYTE, ACK_W, RD_BYTE, MACK, STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t           state;
  logic [7:0]       div_cnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [7:0]       sh;
  logic [7:0]       rx;
  logic [7:0]       reg_q;
  logic             rw_q;
  logic [CNT_W-1:0] cnt;
  logic             nack;
  logic             wr_lat;
  logic             scl_oe;
  logic             sda_oe;
  logic             sda_in;
  logic             hold;
  logic             tick;
  logic             sample;
  logic             slot_end;
  logic             tx_bit;

  assign I2C_SCLK = scl_oe ? 1'b0 : 1'bz;
  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
  assign sda_in   = I2C_SDAT;

`ifdef I2C_CLOCK_STRETCH_EN
  // Only a low SCL that we are not driving ourselves counts as stretching.
  assign hold = ((phase == 2'd1) || (phase == 2'd2)) && !scl_oe && (I2C_SCLK == 1'b0);
`else
  assign hold = 1'b0;
`endif

  assign tick     = (div_cnt == DIV_LAST) && !hold;
  assign sample   = tick && (phase == 2'd2);
  assign slot_end = tick && (phase == 2'd3);
  // The fresh write byte is forwarded while it is being latched so bit 7 is on SDA before SCL rises.
  assign tx_bit   = (state == WR_BYTE && wr_lat) ? wr_data[7] : sh[7];

  // Returns {scl_low, sda_low} for the given slot and phase.
  function automatic logic [1:0] line_drive(input state_t s, input logic [1:0] ph,
                                            input logic tx, input logic more);
    logic scl_l;
    logic sda_l;
    scl_l = (ph == 2'd0) || (ph == 2'd3);
    sda_l = 1'b0;
    case (s)
      IDLE:   scl_l = 1'b0;
      START:  begin scl_l = (ph == 2'd3); sda_l = ph[1]; end
      RSTART: sda_l = ph[1];
      STOP:   begin scl_l = (ph == 2'd0); sda_l = !ph[1]; end
      ADDR_W, REG, ADDR_R, WR_BYTE: sda_l = !tx;
      MACK:   sda_l = more;
      default: ;
    endcase
    return {scl_l, sda_l};
  endfunction

  always_ff @(posedge i2c_clk or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      div_cnt     <= '0;
      phase       <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      rx          <= '0;
      reg_q       <= '0;
      rw_q        <= 1'b0;
      cnt         <= '0;
      nack        <= 1'b0;
      wr_lat      <= 1'b0;
      scl_oe      <= 1'b0;
      sda_oe      <= 1'b0;
      wr_data_req <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
    end else begin
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      wr_data_req <= 1'b0;
      wr_lat      <= wr_data_req;
      {scl_oe, sda_oe} <= line_drive(state, phase, tx_bit, cnt != '0);
      if (wr_lat) sh <= wr_data;

      if (state == IDLE) begin
        div_cnt <= '0;
        phase   <= '0;
        bit_cnt <= '0;
      end else if (!hold) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          phase   <= phase + 2'd1;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end

      if (sample) begin
        rx   <= {rx[6:0], sda_in};
        nack <= sda_in;
      end

      if (state == IDLE) begin
        if (start) begin
          state   <= START;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          rw_q    <= r_w;
          reg_q   <= reg_addr;
          sh      <= {SLAVE_ADDR, 1'b0};
          // A zero-length read still fetches one byte.
          cnt     <= (r_w && num_bytes == '0) ? CNT_W'(1) : num_bytes;
        end
      end else if (slot_end) begin
        case (state)
          START: state <= ADDR_W;
          ADDR_W, REG, ADDR_R, WR_BYTE: begin
            sh      <= {sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              case (state)
                ADDR_W:  state <= ACK_A;
                REG:     state <= ACK_R;
                ADDR_R:  state <= ACK_AR;
                default: begin state <= ACK_W; cnt <= cnt - 1'b1; end
              endcase
            end
          end
          ACK_A, ACK_R, ACK_AR, ACK_W: begin
            if (nack) begin
              ack_err <= 1'b1;
              state   <= STOP;
            end else begin
              case (state)
                ACK_A:  begin state <= REG; sh <= reg_q; end
                ACK_R: begin
                  if (rw_q)           state <= RSTART;
                  else if (cnt == '0) state <= STOP;
                  else begin state <= WR_BYTE; wr_data_req <= 1'b1; end
                end
                ACK_AR: state <= RD_BYTE;
                default: begin
                  if (cnt != '0) begin state <= WR_BYTE; wr_data_req <= 1'b1; end
                  else state <= STOP;
                end
              endcase
            end
          end
          RSTART: begin
            state <= ADDR_R;
            sh    <= {SLAVE_ADDR, 1'b1};
          end
          RD_BYTE: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state    <= MACK;
              rd_data  <= rx;
              rd_valid <= 1'b1;
              cnt      <= cnt - 1'b1;
            end
          end
          MACK: state <= (cnt != '0) ? RD_BYTE : STOP;
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: transaction table, behavioural I2C slave with
// byte/ack scoreboards, plus reset-abort and start-collision sequences.
module tb_i2c_master_burst;
  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 4;

  logic             i2c_clk = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic             r_w = 1'b0;
  logic [7:0]       reg_addr = 8'h00;
  logic [CNT_W-1:0] num_bytes = '0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_data_req;
  logic [7:0]       rd_data;
  logic             rd_valid, busy, done, ack_err;
  wire              scl_bus, sda_bus;

  logic slv_low = 1'b0;
  logic stretch_low = 1'b0;
  logic slv_present = 1'b1;

  pullup (scl_bus);
  pullup (sda_bus);
  assign sda_bus = slv_low ? 1'b0 : 1'bz;
  assign scl_bus = stretch_low ? 1'b0 : 1'bz;

  i2c_master_burst #(.SLAVE_ADDR(7'h18), .CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
    .i2c_clk(i2c_clk), .RST(RST), .start(start), .r_w(r_w), .reg_addr(reg_addr),
    .num_bytes(num_bytes), .wr_data(wr_data), .wr_data_req(wr_data_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .ack_err(ack_err), .I2C_SCLK(scl_bus), .I2C_SDAT(sda_bus)
  );

  always #5 i2c_clk = ~i2c_clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0, rd_cnt = 0, req_cnt = 0, stop_cnt = 0, rise_cnt = 0, per_err = 0;

  logic [7:0] exp_bus[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_src[$];
  logic [7:0] wr_q[$];
  logic       exp_mack[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Upstream write-data source: one cycle of valid data after each request.
  always @(negedge i2c_clk) begin
    logic [7:0] b;
    if (wr_data_req) begin
      req_cnt++;
      if (wr_q.size() == 0) begin fail("wr_req_extra"); b = 8'hEE; end
      else b = wr_q.pop_front();
      @(posedge i2c_clk); #1 wr_data = b;
      @(posedge i2c_clk); #1 wr_data = ~b;
    end
  end

  // Slave model and output monitors.
  logic       scl_q = 1'b1, sda_q = 1'b1;
  int         bitc = 0, cyc = 0, last_rise = 0, stretch_cnt = 0;
  logic [7:0] sh_in = 8'h00, tx_byte = 8'h00;
  logic       tx_mode = 1'b0, tx_pend = 1'b0, last_mack = 1'b1, first = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
  logic       stretch_armed = 1'b1;
`endif

  always @(negedge i2c_clk) begin
    logic s, d;
    s = scl_bus;
    d = sda_bus;
    cyc++;
    if (done) done_cnt++;
    if (rd_valid) begin
      rd_cnt++;
      if (exp_rd.size() == 0) fail("rd_valid_extra");
      else check("rd_data", rd_data, exp_rd.pop_front());
    end
    if (stretch_cnt > 0) begin
      stretch_cnt--;
      if (stretch_cnt == 0) stretch_low = 1'b0;
    end
    if (scl_q && s && sda_q && !d) begin
      bitc = 0; tx_mode = 1'b0; tx_pend = 1'b0; slv_low = 1'b0; first = 1'b1;
    end else if (scl_q && s && !sda_q && d) begin
      stop_cnt++;
      bitc = 0; tx_mode = 1'b0; tx_pend = 1'b0; slv_low = 1'b0;
    end else if (!scl_q && s) begin
      rise_cnt++;
      if (bitc < 8) begin
        if (bitc >= 1 && (cyc - last_rise) != 4 * CLK_DIV) per_err++;
        sh_in = {sh_in[6:0], d};
        bitc++;
      end else if (bitc == 9 && tx_mode) begin
        last_mack = d;
        if (exp_mack.size() == 0) fail("mack_extra");
        else check("master_ack", d, exp_mack.pop_front());
      end
      last_rise = cyc;
    end else if (scl_q && !s) begin
      if (bitc == 8) begin
        bitc = 9;
        if (tx_mode) slv_low = 1'b0;
        else begin
          if (exp_bus.size() == 0) fail("bus_byte_extra");
          else check("bus_byte", sh_in, exp_bus.pop_front());
          slv_low = slv_present;
          if (first && sh_in[0] && slv_present) tx_pend = 1'b1;
          first = 1'b0;
        end
      end else if (bitc == 9) begin
        bitc = 0;
        slv_low = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
        if (stretch_armed) begin
          stretch_armed = 1'b0;
          stretch_low = 1'b1;
          stretch_cnt = 50;
        end
`endif
        if (tx_pend || (tx_mode && !last_mack)) begin
          tx_pend = 1'b0;
          tx_mode = 1'b1;
          tx_byte = (rd_src.size() != 0) ? rd_src.pop_front() : 8'hFF;
          slv_low = !tx_byte[7];
        end else begin
          tx_mode = 1'b0;
        end
      end else if (tx_mode && bitc >= 1 && bitc <= 7) begin
        slv_low = !tx_byte[7 - bitc];
      end
    end
    scl_q = s;
    sda_q = d;
  end

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    int         n;
    logic       present;
    logic [0:5][7:0] d;
    logic       exp_err;
    int         exp_rd;
    int         exp_req;
  } vec_t;

  vec_t vecs[6];

  task automatic flush_queues();
    exp_bus.delete(); exp_rd.delete(); rd_src.delete(); wr_q.delete(); exp_mack.delete();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int neff, d0, r0, q0, s0, p0, c;
    neff = (v.rw && v.n == 0) ? 1 : v.n;
    slv_present = v.present;
    exp_bus.push_back(8'h30);
    if (v.present) begin
      exp_bus.push_back(v.addr);
      if (v.rw) begin
        exp_bus.push_back(8'h31);
        for (int i = 0; i < neff; i++) begin
          rd_src.push_back(v.d[i]);
          exp_rd.push_back(v.d[i]);
          exp_mack.push_back(i == neff - 1);
        end
      end else begin
        for (int i = 0; i < v.n; i++) begin
          wr_q.push_back(v.d[i]);
          exp_bus.push_back(v.d[i]);
        end
      end
    end
    d0 = done_cnt; r0 = rd_cnt; q0 = req_cnt; s0 = stop_cnt; p0 = per_err;
    @(posedge i2c_clk); #1;
    start = 1'b1; r_w = v.rw; reg_addr = v.addr; num_bytes = v.n[CNT_W-1:0];
    @(posedge i2c_clk); #1;
    start = 1'b0; r_w = ~v.rw; reg_addr = ~v.addr; num_bytes = '1;
    @(negedge i2c_clk);
    check($sformatf("v%0d_busy_on_start", idx), busy, 1'b1);
    check($sformatf("v%0d_ack_err_cleared", idx), ack_err, 1'b0);
    repeat (20) @(posedge i2c_clk);
    #1 start = 1'b1;
    @(posedge i2c_clk); #1 start = 1'b0;
    for (c = 0; c < 6000 && done_cnt == d0; c++) @(negedge i2c_clk);
    if (done_cnt == d0) fail($sformatf("v%0d_done_timeout", idx));
    repeat (10) @(negedge i2c_clk);
    check($sformatf("v%0d_ack_err", idx), ack_err, v.exp_err);
    check($sformatf("v%0d_busy_idle", idx), busy, 1'b0);
    check($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 1);
    check($sformatf("v%0d_rd_valid_pulses", idx), rd_cnt - r0, v.exp_rd);
    check($sformatf("v%0d_wr_req_pulses", idx), req_cnt - q0, v.exp_req);
    check($sformatf("v%0d_stops", idx), stop_cnt - s0, 1);
    check($sformatf("v%0d_leftover", idx),
          exp_bus.size() + exp_rd.size() + exp_mack.size() + wr_q.size(), 0);
`ifndef I2C_CLOCK_STRETCH_EN
    check($sformatf("v%0d_bit_period", idx), per_err - p0, 0);
`endif
    flush_queues();
  endtask

  initial begin
    int r0, c;
    vecs[0] = '{1'b0, 8'h0F, 1, 1'b1, {8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 0, 1};
    vecs[1] = '{1'b1, 8'h02, 6, 1'b1, {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16}, 1'b0, 6, 0};
    vecs[2] = '{1'b1, 8'h02, 2, 1'b0, {8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 0, 0};
    vecs[3] = '{1'b0, 8'h20, 3, 1'b1, {8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'h00}, 1'b0, 0, 3};
    vecs[4] = '{1'b0, 8'h44, 0, 1'b1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 0, 0};
    vecs[5] = '{1'b1, 8'h07, 0, 1'b1, {8'h9C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1, 0};

    repeat (3) @(negedge i2c_clk);
    check("rst_scl", scl_bus, 1'b1);
    check("rst_sda", sda_bus, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_wr_req", wr_data_req, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    RST = 1'b0;
    repeat (3) @(negedge i2c_clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort during the 4th bit of the register byte.
    slv_present = 1'b1;
    exp_bus.push_back(8'h30);
    r0 = rise_cnt;
    @(posedge i2c_clk); #1;
    start = 1'b1; r_w = 1'b0; reg_addr = 8'h0F; num_bytes = 4'd1;
    @(posedge i2c_clk); #1 start = 1'b0;
    for (c = 0; c < 3000 && rise_cnt < r0 + 13; c++) @(negedge i2c_clk);
    if (rise_cnt < r0 + 13) fail("abort_wait_timeout");
    @(posedge i2c_clk); #2 RST = 1'b1;
    #1;
    check("abort_scl", scl_bus, 1'b1);
    check("abort_sda", sda_bus, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_rd_data", rd_data, 8'h00);
    check("abort_ack_err", ack_err, 1'b0);
    check("abort_outputs", {done, rd_valid, wr_data_req}, 3'b000);
    repeat (3) @(posedge i2c_clk);
    #1 RST = 1'b0;
    repeat (3) @(negedge i2c_clk);
    check("abort_leftover", exp_bus.size(), 0);
    flush_queues();
    run_vec(vecs[0], 6);

    // Reset and start in the same cycle: reset wins.
    @(posedge i2c_clk); #1 RST = 1'b1; start = 1'b1; r_w = 1'b1;
    @(posedge i2c_clk); #1 RST = 1'b0; start = 1'b0;
    repeat (4) @(negedge i2c_clk);
    check("rst_start_busy", busy, 1'b0);
    check("rst_start_scl", scl_bus, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
